// File: rtl/binary_to_ascii_converter.sv
// binary_to_ascii_converter
//   Converts an unsigned BIN_WIDTH-bit word into ASCII decimal characters,
//   most significant digit first, one character per valid/ready handshake.
//   Conversion is shift-add-3 (double dabble), one input bit per cycle.
//
// Ports:
//   clk              clock, posedge
//   rst_n            asynchronous active-low reset
//   bin_in           value to convert, sampled when start is accepted
//   start_in         conversion request, accepted only while idle
//   busy_out         high whenever a conversion/emission is in progress
//   ascii_out        current character (8'h30 + digit), 8'h00 when idle
//   ascii_valid_out  ascii_out holds a valid character
//   ascii_ready_in   downstream accepts the character
//   ascii_last_out   marks the least significant (final) character
module binary_to_ascii_converter #(
  parameter int unsigned BIN_WIDTH      = 32,
  parameter int unsigned DIGITS         = 10,
  parameter bit          SUPPRESS_ZEROS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic                 start_in,
  output logic                 busy_out,
  output logic [7:0]           ascii_out,
  output logic                 ascii_valid_out,
  input  logic                 ascii_ready_in,
  output logic                 ascii_last_out
);

  localparam int unsigned BCD_W      = DIGITS * 4;
  localparam int unsigned CNT_W      = $clog2(BIN_WIDTH + 1);
  localparam int unsigned IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // ceil(BIN_WIDTH * log10(2)) in integer arithmetic
  localparam int unsigned MIN_DIGITS = (BIN_WIDTH * 30103 + 99999) / 100000;

  if (DIGITS < MIN_DIGITS) begin : g_digits_check
    $error("DIGITS too small to hold a %0d-bit value", BIN_WIDTH);
  end

  typedef enum logic [1:0] {IDLE, CONVERT, FIND, EMIT} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic [BCD_W-1:0]     bcd_adj;
  logic [IDX_W-1:0]     msd_idx;
  logic [3:0]           digit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Add 3 to every BCD nibble >= 5 ahead of the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Highest nonzero nibble; stays 0 when the whole value is zero
  always_comb begin
    msd_idx = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] != 4'd0) begin
        msd_idx = IDX_W'(i);
      end
    end
  end

  assign digit = 4'(bcd_q >> {idx_q, 2'b00});

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = CONVERT;
      CONVERT: if (cnt_q == CNT_W'(1)) state_d = FIND;
      FIND:    state_d = EMIT;
      EMIT:    if (ascii_ready_in && (idx_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          bin_d = bin_in;
          bcd_d = '0;
          cnt_d = CNT_W'(BIN_WIDTH);
        end
      end
      CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q - CNT_W'(1);
      end
      FIND: begin
        idx_d = SUPPRESS_ZEROS ? msd_idx : IDX_W'(DIGITS - 1);
      end
      EMIT: begin
        if (ascii_ready_in && (idx_q != '0)) begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    busy_out        = (state_q != IDLE);
    ascii_valid_out = (state_q == EMIT);
    ascii_last_out  = (state_q == EMIT) && (idx_q == '0);
    ascii_out       = (state_q == EMIT) ? (8'h30 + {4'h0, digit}) : 8'h00;
  end

endmodule

// File: tb/tb_binary_to_ascii_converter.sv
// Scoreboard bench for binary_to_ascii_converter: instance 0 suppresses
// leading zeros, instance 1 emits all ten digits.
module tb_binary_to_ascii_converter;

  typedef struct {
    logic [7:0] ch;
    logic       last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] bin;
  logic        start [2];
  logic        ready [2];
  logic        busy  [2];
  logic        valid [2];
  logic        last  [2];
  logic [7:0]  ascii [2];
  int          rmode [2];   // 0: ready high, 1: random, 2: ready low

  exp_t        q [2][$];
  int          checks = 0;
  int          errors = 0;

  logic        stall     [2];
  logic [7:0]  held_ch   [2];
  logic        held_last [2];

  binary_to_ascii_converter #(.BIN_WIDTH(32), .DIGITS(10), .SUPPRESS_ZEROS(1'b1)) u_dut_sz (
    .clk(clk), .rst_n(rst_n), .bin_in(bin), .start_in(start[0]), .busy_out(busy[0]),
    .ascii_out(ascii[0]), .ascii_valid_out(valid[0]), .ascii_ready_in(ready[0]),
    .ascii_last_out(last[0])
  );

  binary_to_ascii_converter #(.BIN_WIDTH(32), .DIGITS(10), .SUPPRESS_ZEROS(1'b0)) u_dut_pad (
    .clk(clk), .rst_n(rst_n), .bin_in(bin), .start_in(start[1]), .busy_out(busy[1]),
    .ascii_out(ascii[1]), .ascii_valid_out(valid[1]), .ascii_ready_in(ready[1]),
    .ascii_last_out(last[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits of v, optionally without leading zeros
  function automatic string ref_str(input longint unsigned v, input bit sz);
    string s = "";
    for (int i = 0; i < 10; i++) begin
      s = {$sformatf("%0d", v % 10), s};
      v = v / 10;
    end
    if (sz) begin
      while (s.len() > 1 && s[0] == 8'h30) s = s.substr(1, s.len() - 1);
    end
    return s;
  endfunction

  task automatic push_exp(input int k, input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.ch   = s[i];
      e.last = (i == s.len() - 1);
      q[k].push_back(e);
    end
  endtask

  // Ready drivers
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      case (rmode[k])
        0:       ready[k] = 1'b1;
        1:       ready[k] = 1'($urandom_range(0, 1));
        default: ready[k] = 1'b0;
      endcase
    end
  end

  // Monitor: handshakes complete on the next posedge, sampled at negedge
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        stall[k] = 1'b0;
      end else begin
        if (stall[k]) begin
          chk("hold_valid", valid[k], 1);
          chk("hold_char", ascii[k], held_ch[k]);
          chk("hold_last", last[k], held_last[k]);
        end
        if (valid[k] && ready[k]) begin
          if (q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_char: inst %0d got %0h expected none", k, ascii[k]);
          end else begin
            e = q[k].pop_front();
            chk("char", ascii[k], e.ch);
            chk("last", last[k], e.last);
          end
        end
        stall[k]     = valid[k] && !ready[k];
        held_ch[k]   = ascii[k];
        held_last[k] = last[k];
      end
    end
  end

  // Issue start, then check busy and the exact first-valid latency
  task automatic start_conv(input int k, input logic [31:0] v);
    @(posedge clk); #1;
    bin      = v;
    start[k] = 1'b1;
    push_exp(k, ref_str(v, k == 0));
    @(posedge clk); #1;
    start[k] = 1'b0;
    bin      = $urandom;
    chk("busy_after_start", busy[k], 1);
    repeat (32) @(posedge clk);
    #1 chk("no_early_valid", valid[k], 0);
    @(posedge clk); #1;
    chk("first_valid_latency", valid[k], 1);
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", n < 300, 1);
    chk("queue_drained", q[k].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    rst_n    = 1'b0;
    bin      = '0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    ready[0] = 1'b1;
    ready[1] = 1'b1;
    rmode[0] = 0;
    rmode[1] = 0;
    stall[0] = 1'b0;
    stall[1] = 1'b0;
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", busy[k], 0);
      chk("rst_valid", valid[k], 0);
      chk("rst_last", last[k], 0);
      chk("rst_ascii", ascii[k], 0);
    end
    #1 rst_n = 1'b1;

    // 1234 at full rate; start held through EMIT including the final handshake
    start_conv(0, 32'd1234);
    start[0] = 1'b1;
    bin      = 32'd5;
    repeat (4) @(posedge clk);
    #1;
    start[0] = 1'b0;
    chk("busy_low_after_last", busy[0], 0);
    @(posedge clk); #1;
    chk("start_during_emit_ignored", busy[0], 0);
    wait_idle(0);

    start_conv(0, 32'd0);
    wait_idle(0);
    start_conv(0, 32'hFFFF_FFFF);
    wait_idle(0);

    rmode[0] = 1;
    start_conv(0, 32'd987);
    wait_idle(0);

    for (int i = 0; i < 10; i++) begin
      rmode[0] = i % 2;
      v = (i % 3 == 0) ? 32'($urandom_range(0, 999)) : $urandom;
      start_conv(0, v);
      wait_idle(0);
    end

    // Reset while a character is stalled
    rmode[0] = 2;
    start_conv(0, 32'd1234);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_valid", valid[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_last", last[0], 0);
    chk("abort_ascii", ascii[0], 0);
    q[0].delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rmode[0] = 0;
    start_conv(0, 32'd7);
    wait_idle(0);

    // Zero-padded instance
    start_conv(1, 32'd42);
    wait_idle(1);
    rmode[1] = 1;
    start_conv(1, $urandom);
    wait_idle(1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
